io_port_unit: RTL and testbench

- Downstream consumer of the CPU core's I/O strobes (ioWe/ioRe), ACC value and SRC register-pair address.
- Implements the 4004-style ROM I/O ports (WRR write, RDR read) and RAM output ports (WMP).
- Owns the SRC address latch, per-port output latches, per-port write-strobe pulses and an input synchronizer for external ROM-port pins.
- Returns RDR data to the core's ACC path with a registered valid pulse.

---
 rtl/io_port_unit.sv | 123 ++++++++++++
 tb/tb_io_port_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_unit.sv
// 4004-style I/O port block: SRC address latch, ROM I/O ports (WRR/RDR), RAM output ports (WMP),
// pin synchronizer for ROM-port inputs and a sticky protocol-error flag.
module io_port_unit #(
  parameter int NUM_ROM_PORTS  = 16,
  parameter int NUM_BANKS      = 4,
  parameter int CHIPS_PER_BANK = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    srcWe,
  input  logic [7:0]                              srcAddr,
  input  logic [3:0]                              bankSel,
  input  logic                                    ioWe,
  input  logic                                    ioRe,
  input  logic [1:0]                              ioSel,
  input  logic [3:0]                              accIn,
  input  logic [4*NUM_ROM_PORTS-1:0]              romPortIn,
  output logic [3:0]                              ioData,
  output logic                                    ioDataValid,
  output logic [4*NUM_ROM_PORTS-1:0]              romPortOut,
  output logic [NUM_ROM_PORTS-1:0]                romPortStrobe,
  output logic [4*NUM_BANKS*CHIPS_PER_BANK-1:0]   ramPortOut,
  output logic                                    protoErr
);

  localparam int RamPorts = NUM_BANKS * CHIPS_PER_BANK;

  logic [7:0]                 srcLatch_r;
  logic [4*NUM_ROM_PORTS-1:0] sync_r [SYNC_STAGES];
  int                         romIdx_s;
  int                         ramIdx_s;
  logic [3:0]                 rdNib_s;
  logic                       doWrr_s;
  logic                       doWmp_s;
  logic                       doRdr_s;
  logic                       errHit_s;
  logic                       unusedBits_s;

  assign romIdx_s     = int'(srcLatch_r[7:4]);
  assign ramIdx_s     = int'(bankSel[1:0]) * CHIPS_PER_BANK + int'(srcLatch_r[7:6]);
  assign unusedBits_s = ^{bankSel[3:2], srcLatch_r[3:0]};

  // Operation decode; any strobe that does not form a legal operation is a protocol error
  always_comb begin
    doWrr_s  = 1'b0;
    doWmp_s  = 1'b0;
    doRdr_s  = 1'b0;
    case ({ioWe, ioRe})
      2'b10: begin
        case (ioSel)
          2'b00:   doWrr_s = 1'b1;
          2'b01:   doWmp_s = 1'b1;
          default: doWrr_s = 1'b0;
        endcase
      end
      2'b01:   doRdr_s = (ioSel == 2'b10);
      default: doRdr_s = 1'b0;
    endcase
    errHit_s = (ioWe | ioRe) & ~(doWrr_s | doWmp_s | doRdr_s);
  end

  // Read mux over the synchronized pins of the port addressed by srcLatch[7:4]
  always_comb begin
    rdNib_s = 4'h0;
    for (int p = 0; p < NUM_ROM_PORTS; p++) begin
      rdNib_s = rdNib_s | ({4{romIdx_s == p}} & sync_r[SYNC_STAGES-1][4*p +: 4]);
    end
  end

  // Free-running pin synchronizer, SYNC_STAGES flops deep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= '0;
      end
    end else begin
      sync_r[0] <= romPortIn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  // SRC latch, output latches, strobes, read-data return and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      srcLatch_r    <= 8'h00;
      romPortOut    <= '0;
      romPortStrobe <= '0;
      ramPortOut    <= '0;
      ioData        <= 4'h0;
      ioDataValid   <= 1'b0;
      protoErr      <= 1'b0;
    end else begin
      // Same-cycle I/O uses the old address because decode reads srcLatch_r
      if (srcWe) begin
        srcLatch_r <= srcAddr;
      end
      romPortStrobe <= '0;
      ioDataValid   <= 1'b0;
      for (int p = 0; p < NUM_ROM_PORTS; p++) begin
        if (doWrr_s && (romIdx_s == p)) begin
          romPortOut[4*p +: 4] <= accIn;
          romPortStrobe[p]     <= 1'b1;
        end
      end
      for (int r = 0; r < RamPorts; r++) begin
        if (doWmp_s && (ramIdx_s == r)) begin
          ramPortOut[4*r +: 4] <= accIn;
        end
      end
      if (doRdr_s) begin
        ioData      <= rdNib_s;
        ioDataValid <= 1'b1;
      end
      if (errHit_s) begin
        protoErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: per-cycle comparison against a port-array model
// plus hand-computed literal expectations.
module tb_io_port_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        srcWe;
  logic [7:0]  srcAddr;
  logic [3:0]  bankSel;
  logic        ioWe;
  logic        ioRe;
  logic [1:0]  ioSel;
  logic [3:0]  accIn;
  logic [63:0] pins;
  logic [3:0]  ioData;
  logic        ioDataValid;
  logic [63:0] romPortOut;
  logic [15:0] romPortStrobe;
  logic [63:0] ramPortOut;
  logic        protoErr;

  int compared = 0;
  int mismatched = 0;

  io_port_unit dut (
    .clk(clk), .rst(rst), .srcWe(srcWe), .srcAddr(srcAddr), .bankSel(bankSel),
    .ioWe(ioWe), .ioRe(ioRe), .ioSel(ioSel), .accIn(accIn), .romPortIn(pins),
    .ioData(ioData), .ioDataValid(ioDataValid), .romPortOut(romPortOut),
    .romPortStrobe(romPortStrobe), .ramPortOut(ramPortOut), .protoErr(protoErr)
  );

  always #5 clk = ~clk;

  // Behavioural model: arrays of port values, address register, pin delay line
  logic [3:0]  romM [16];
  logic [3:0]  ramM [16];
  logic [7:0]  srcM;
  logic [3:0]  ioDataM;
  logic        validM;
  logic [15:0] strobeM;
  logic        errM;
  logic [63:0] pinQ [$];
  logic [63:0] visM;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        romM[i] = 4'h0;
        ramM[i] = 4'h0;
      end
      srcM = 8'h00; ioDataM = 4'h0; validM = 1'b0; strobeM = 16'h0; errM = 1'b0;
      pinQ.delete();
      repeat (2) pinQ.push_back(64'h0);
    end else begin
      visM = pinQ.pop_front();
      pinQ.push_back(pins);
      validM = 1'b0;
      strobeM = 16'h0;
      if (ioWe && ioRe) errM = 1'b1;
      else if (ioWe) begin
        if (ioSel == 2'd0) begin
          romM[srcM[7:4]] = accIn;
          strobeM[srcM[7:4]] = 1'b1;
        end else if (ioSel == 2'd1) ramM[bankSel[1:0] * 4 + srcM[7:6]] = accIn;
        else errM = 1'b1;
      end else if (ioRe) begin
        if (ioSel == 2'd2) begin
          ioDataM = visM[srcM[7:4] * 4 +: 4];
          validM = 1'b1;
        end else errM = 1'b1;
      end
      if (srcWe) srcM = srcAddr;
    end
  end

  function automatic logic [63:0] packRom();
    logic [63:0] v;
    for (int i = 0; i < 16; i++) v[4*i +: 4] = romM[i];
    return v;
  endfunction

  function automatic logic [63:0] packRam();
    logic [63:0] v;
    for (int i = 0; i < 16; i++) v[4*i +: 4] = ramM[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("m_romPortOut", romPortOut, packRom());
      chk("m_ramPortOut", ramPortOut, packRam());
      chk("m_ioData", {60'h0, ioData}, {60'h0, ioDataM});
      chk("m_ioDataValid", {63'h0, ioDataValid}, {63'h0, validM});
      chk("m_romPortStrobe", {48'h0, romPortStrobe}, {48'h0, strobeM});
      chk("m_protoErr", {63'h0, protoErr}, {63'h0, errM});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic doSrc(input logic [7:0] a);
    srcWe = 1'b1; srcAddr = a;
    tick();
    srcWe = 1'b0;
  endtask

  task automatic doOp(input logic we, input logic re, input logic [1:0] sel, input logic [3:0] acc);
    ioWe = we; ioRe = re; ioSel = sel; accIn = acc;
    tick();
    ioWe = 1'b0; ioRe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; srcWe = 1'b0; srcAddr = 8'h00; bankSel = 4'h0;
    ioWe = 1'b0; ioRe = 1'b0; ioSel = 2'b00; accIn = 4'h0;
    pins = 64'hFEDC_BA98_7654_3210;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_rom", romPortOut, 64'h0);
    chk("reset_err", {63'h0, protoErr}, 64'h0);

    // Preload: ROM port p <- p+1, RAM (bank b, chip c) <- b*4+c
    for (int p = 0; p < 16; p++) begin
      doSrc({p[3:0], 4'h0});
      doOp(1'b1, 1'b0, 2'b00, 4'(p + 1));
    end
    chk("preload_rom", romPortOut, 64'h0FED_CBA9_8765_4321);
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 4; c++) begin
        bankSel = 4'(b);
        doSrc({c[1:0], 6'h00});
        doOp(1'b1, 1'b0, 2'b01, 4'(b * 4 + c));
      end
    end
    chk("preload_ram", ramPortOut, 64'hFEDC_BA98_7654_3210);

    // WRR to port 3
    doSrc(8'h3A);
    doOp(1'b1, 1'b0, 2'b00, 4'h9);
    chk("wrr_port3", {60'h0, romPortOut[15:12]}, 64'h9);
    chk("wrr_strobe", {48'h0, romPortStrobe}, 64'h0008);
    chk("wrr_others", romPortOut, 64'h0FED_CBA9_8765_9321);
    tick();
    chk("wrr_strobe_clr", {48'h0, romPortStrobe}, 64'h0);

    // SRC and WRR in the same cycle: write uses the old address
    doSrc(8'h10);
    srcWe = 1'b1; srcAddr = 8'h20;
    doOp(1'b1, 1'b0, 2'b00, 4'h5);
    srcWe = 1'b0;
    chk("samecyc_p1", {60'h0, romPortOut[7:4]}, 64'h5);
    chk("samecyc_p2", {60'h0, romPortOut[11:8]}, 64'h3);
    doOp(1'b1, 1'b0, 2'b00, 4'h6);
    chk("next_p2", {60'h0, romPortOut[11:8]}, 64'h6);

    // WMP bank 2 chip 3 -> index 11
    bankSel = 4'h2;
    doSrc(8'hC0);
    doOp(1'b1, 1'b0, 2'b01, 4'hE);
    chk("wmp_idx11", {60'h0, ramPortOut[47:44]}, 64'hE);
    chk("wmp_others", ramPortOut, 64'hFEDC_EA98_7654_3210);
    chk("wmp_nostrobe", {48'h0, romPortStrobe}, 64'h0);

    // RDR of port 7 across a pin change
    doSrc(8'h70);
    pins[31:28] = 4'h5;
    tick();
    ioRe = 1'b1; ioSel = 2'b10;
    tick();
    chk("rdr_old", {60'h0, ioData}, 64'h7);
    chk("rdr_old_v", {63'h0, ioDataValid}, 64'h1);
    tick();
    ioRe = 1'b0;
    chk("rdr_new", {60'h0, ioData}, 64'h5);
    chk("rdr_new_v", {63'h0, ioDataValid}, 64'h1);
    tick();
    chk("rdr_v_clr", {63'h0, ioDataValid}, 64'h0);
    chk("rdr_hold", {60'h0, ioData}, 64'h5);

    // Protocol error: both strobes
    chk("err_pre", {63'h0, protoErr}, 64'h0);
    doOp(1'b1, 1'b1, 2'b00, 4'h3);
    chk("err_set", {63'h0, protoErr}, 64'h1);
    chk("err_nowrite", {60'h0, romPortOut[31:28]}, 64'h8);
    chk("err_nostrobe", {48'h0, romPortStrobe}, 64'h0);
    chk("err_novalid", {63'h0, ioDataValid}, 64'h0);
    doOp(1'b1, 1'b0, 2'b00, 4'hC);
    chk("err_legal_wr", {60'h0, romPortOut[31:28]}, 64'hC);
    chk("err_sticky", {63'h0, protoErr}, 64'h1);
    doOp(1'b1, 1'b0, 2'b10, 4'h1);
    doOp(1'b1, 1'b0, 2'b11, 4'h2);

    // Asynchronous reset mid-run
    rst = 1'b1;
    #1;
    chk("rst_rom", romPortOut, 64'h0);
    chk("rst_ram", ramPortOut, 64'h0);
    chk("rst_io", {59'h0, ioDataValid, ioData}, 64'h0);
    chk("rst_strobe", {48'h0, romPortStrobe}, 64'h0);
    chk("rst_err", {63'h0, protoErr}, 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_rom", romPortOut, 64'h0);
    chk("post_rst_err", {63'h0, protoErr}, 64'h0);

    // Read with wrong ioSel is an error; then a legal WRR to port 0
    doOp(1'b0, 1'b1, 2'b01, 4'h0);
    chk("err_rdsel", {63'h0, protoErr}, 64'h1);
    chk("err_rdsel_v", {63'h0, ioDataValid}, 64'h0);
    doOp(1'b1, 1'b0, 2'b00, 4'hF);
    chk("wrr_p0", romPortOut, 64'h000F);
    chk("wrr_p0_strobe", {48'h0, romPortStrobe}, 64'h0001);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
